ysyx_22050710_axil_arbiter: RTL and testbench
=============================================

// Module: ysyx_22050710_axil_arbiter
// PURPOSE
//  2-master -> 1-slave AXI4-Lite arbiter between cpu_top and a single unified SRAM wrap.
//  m0 = IFU port, m1 = LSU port, s = memory port. Read and write paths are arbitrated independently.
//  Each path has one outstanding transaction; grant is round-robin.
// PARAMETERS
//  ADDR_WD  64          address width (matches SRAM_ADDR_WD)
//  DATA_WD  64          data width (matches SRAM_DATA_WD)
//  STRB_WD  DATA_WD/8   write-strobe width, derived, not overridable
// PORTS  (m{0,1} = one identical set per master; s = slave side, directions mirrored)
//  i_aclk                          in   1          clock
//  i_arsetn                        in   1          asynchronous active-low reset
//  i_m{0,1}_awvalid/awaddr/awprot  in   1/AW/3     master write address; o_m{0,1}_awready out 1
//  i_m{0,1}_wvalid/wdata/wstrb     in   1/DW/SW    master write data; o_m{0,1}_wready out 1
//  o_m{0,1}_bvalid/bresp           out  1/2        write response; i_m{0,1}_bready in 1
//  i_m{0,1}_arvalid/araddr/arprot  in   1/AW/3     master read address; o_m{0,1}_arready out 1
//  o_m{0,1}_rvalid/rdata/rresp     out  1/DW/2     read data; i_m{0,1}_rready in 1
//  o_s_aw*/o_s_w*/i_s_b*           -    as above   slave write channels, driven from granted master
//  o_s_ar*/i_s_r*                  -    as above   slave read channels, driven from granted master
// BEHAVIOUR
//  Reset (async, i_arsetn=0):
//   - both FSMs go to IDLE; all o_*valid/o_*ready = 0; all o_s addr/data/strb/prot = 0
//   - both rr pointers = 0 (m1 has priority)
//  Read FSM R_IDLE -> R_AR -> R_R -> R_IDLE:
//   - R_IDLE: all read outputs 0; if any m_arvalid, grant per rr and latch grant -> R_AR (1-cycle arb latency)
//   - R_AR: o_s_arvalid=1; o_s_araddr/arprot = granted master's; granted o_m_arready = i_s_arready (comb)
//   - R_AR: on s ar handshake -> R_R
//   - R_R: granted o_m_rvalid/rdata/rresp = slave's; o_s_rready = granted i_m_rready
//   - R_R: on r handshake -> R_IDLE; pointer := granted id
//  Write FSM W_IDLE -> W_AW -> W_B -> W_IDLE:
//   - W_IDLE: arbitrate on m_awvalid only
//   - W_AW: forward AW and W concurrently; regs aw_done/w_done set on each slave handshake
//   - W_AW: that channel's valid deasserts once done; both done -> W_B (same-cycle completion allowed)
//   - W_B: forward b to granted master; on b handshake -> W_IDLE; clear done flags; update pointer
//  Non-granted master: all ready/valid outputs 0 (backpressured); its inputs are ignored.
//  Round-robin on tie: master != last granted wins; single requester always wins.
//  Pointer update is per path, on completion only.
//  Responses (incl. SLVERR/DECERR) are forwarded unchanged; no read/write ordering between paths.
//  Slave stall: o_s_* address/data held stable until the handshake.
//  Master dropping valid after grant: ignored, because the latched grant holds.
//  Reset mid-transaction: transaction dropped, outputs 0 at once (async); no replay.
// STRUCTURE
//  defines.v: FSM state encodings (R_/W_ IDLE,AW/AR,B/R) and AXI resp codes OKAY=2'b00, SLVERR=2'b10.
//  Sub-module ysyx_22050710_rr_arb2: 2-way req -> one-hot grant plus pointer reg; instantiated for read and for write.
//  Datapath: 2:1 muxes selected by the latched grant bit.
// TESTING
//  1. m0 ar 0x8000_0000; slave arready=1, r data 0x00000413 next cycle
//     -> o_s_arvalid 1 cycle after req; m0 rdata=0x413, rresp=0; m1 rvalid stays 0.
//  2. After reset, m0+m1 arvalid same cycle (0x8000_0000 / 0x8000_1000)
//     -> s sees 0x8000_1000 first, then 0x8000_0000.
//     Repeat tie -> m0 served first.
//  3. m1 aw 0x8000_2000 at t0, w 0xdead_beef strb 0x0f at t2, slave bresp=2'b10
//     -> W held until w handshake; m1 gets bresp=2'b10; m0 bvalid never 1.
//  4. m0 read and m1 write requested same cycle -> both slave channels active same cycles, neither blocks.
//  5. Slave arready low 5 cycles -> o_s_arvalid/araddr stable for all 5; granted m0_arready low; m1 never readied.
//  6. i_arsetn low during R_R -> all valids/readies 0 immediately; after release, a fresh m1 read completes normally.

Source files
------------

// File: rtl/ysyx_22050710_axil_arbiter_pkg.sv
// Shared types and constants for the 2-master AXI4-Lite arbiter.
package ysyx_22050710_axil_arbiter_pkg;

    // Read path: arbitrate, forward AR, forward R.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_t;

    // Write path: arbitrate, forward AW+W, forward B.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } w_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One-hot grant to master id (bit 1 set means m1).
    function automatic logic grant_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/ysyx_22050710_rr_arb2.sv
// Two-way round-robin arbiter. The pointer holds the id of the last master
// that completed a transaction; on a tie the other master wins.
module ysyx_22050710_rr_arb2 (
    input  logic       i_aclk,
    input  logic       i_arsetn,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_upd_id,
    output logic [1:0] o_grant
);

    logic ptr;

    // Pointer advances only when the path finishes a transaction.
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            ptr <= 1'b0;
        end else if (i_update) begin
            ptr <= i_upd_id;
        end
    end

    // Single requester always wins; a tie goes to the master that was not last.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = ptr ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_22050710_axil_arbiter.sv
// 2-master to 1-slave AXI4-Lite arbiter. Read and write paths run independent
// FSMs, each with one outstanding transaction and its own round-robin pointer.
// Handshake rule: a transfer happens on a rising clock edge where valid and
// ready are both high; the slave-side address/data are steered from the latched
// grant so they stay stable while the slave stalls.
module ysyx_22050710_axil_arbiter
    import ysyx_22050710_axil_arbiter_pkg::*;
#(
    parameter  int ADDR_WD = 64,
    parameter  int DATA_WD = 64,
    localparam int STRB_WD = DATA_WD / 8
) (
    input  logic               i_aclk,
    input  logic               i_arsetn,
    // master 0 (IFU)
    input  logic               i_m0_awvalid,
    input  logic [ADDR_WD-1:0] i_m0_awaddr,
    input  logic [2:0]         i_m0_awprot,
    output logic               o_m0_awready,
    input  logic               i_m0_wvalid,
    input  logic [DATA_WD-1:0] i_m0_wdata,
    input  logic [STRB_WD-1:0] i_m0_wstrb,
    output logic               o_m0_wready,
    output logic               o_m0_bvalid,
    output logic [1:0]         o_m0_bresp,
    input  logic               i_m0_bready,
    input  logic               i_m0_arvalid,
    input  logic [ADDR_WD-1:0] i_m0_araddr,
    input  logic [2:0]         i_m0_arprot,
    output logic               o_m0_arready,
    output logic               o_m0_rvalid,
    output logic [DATA_WD-1:0] o_m0_rdata,
    output logic [1:0]         o_m0_rresp,
    input  logic               i_m0_rready,
    // master 1 (LSU)
    input  logic               i_m1_awvalid,
    input  logic [ADDR_WD-1:0] i_m1_awaddr,
    input  logic [2:0]         i_m1_awprot,
    output logic               o_m1_awready,
    input  logic               i_m1_wvalid,
    input  logic [DATA_WD-1:0] i_m1_wdata,
    input  logic [STRB_WD-1:0] i_m1_wstrb,
    output logic               o_m1_wready,
    output logic               o_m1_bvalid,
    output logic [1:0]         o_m1_bresp,
    input  logic               i_m1_bready,
    input  logic               i_m1_arvalid,
    input  logic [ADDR_WD-1:0] i_m1_araddr,
    input  logic [2:0]         i_m1_arprot,
    output logic               o_m1_arready,
    output logic               o_m1_rvalid,
    output logic [DATA_WD-1:0] o_m1_rdata,
    output logic [1:0]         o_m1_rresp,
    input  logic               i_m1_rready,
    // slave (memory)
    output logic               o_s_awvalid,
    output logic [ADDR_WD-1:0] o_s_awaddr,
    output logic [2:0]         o_s_awprot,
    input  logic               i_s_awready,
    output logic               o_s_wvalid,
    output logic [DATA_WD-1:0] o_s_wdata,
    output logic [STRB_WD-1:0] o_s_wstrb,
    input  logic               i_s_wready,
    input  logic               i_s_bvalid,
    input  logic [1:0]         i_s_bresp,
    output logic               o_s_bready,
    output logic               o_s_arvalid,
    output logic [ADDR_WD-1:0] o_s_araddr,
    output logic [2:0]         o_s_arprot,
    input  logic               i_s_arready,
    input  logic               i_s_rvalid,
    input  logic [DATA_WD-1:0] i_s_rdata,
    input  logic [1:0]         i_s_rresp,
    output logic               o_s_rready,
    // FSM state observation
    output logic [1:0]         o_dbg_r_state,
    output logic [1:0]         o_dbg_w_state
);

    r_state_t   r_state, r_next;
    w_state_t   w_state, w_next;
    logic       r_gnt, w_gnt;
    logic [1:0] r_grant, w_grant;
    logic       r_done, b_done;
    logic       aw_done, w_done, aw_fire, w_fire, m_wvalid;

    assign o_dbg_r_state = r_state;
    assign o_dbg_w_state = w_state;

    ysyx_22050710_rr_arb2 u_rd_arb (
        .i_aclk   (i_aclk),
        .i_arsetn (i_arsetn),
        .i_req    ({i_m1_arvalid, i_m0_arvalid}),
        .i_update (r_done),
        .i_upd_id (r_gnt),
        .o_grant  (r_grant)
    );

    ysyx_22050710_rr_arb2 u_wr_arb (
        .i_aclk   (i_aclk),
        .i_arsetn (i_arsetn),
        .i_req    ({i_m1_awvalid, i_m0_awvalid}),
        .i_update (b_done),
        .i_upd_id (w_gnt),
        .o_grant  (w_grant)
    );

    assign r_done   = (r_state == R_R) && i_s_rvalid && (r_gnt ? i_m1_rready : i_m0_rready);
    assign b_done   = (w_state == W_B) && i_s_bvalid && (w_gnt ? i_m1_bready : i_m0_bready);
    assign m_wvalid = w_gnt ? i_m1_wvalid : i_m0_wvalid;
    assign aw_fire  = (w_state == W_AW) && !aw_done && i_s_awready;
    assign w_fire   = (w_state == W_AW) && !w_done && m_wvalid && i_s_wready;

    // Read state register and grant latch.
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            r_state <= R_IDLE;
            r_gnt   <= 1'b0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && r_grant != 2'b00) r_gnt <= grant_id(r_grant);
        end
    end

    // Read next state and channel steering; non-granted master sees all zeros.
    always_comb begin
        r_next       = r_state;
        o_s_arvalid  = 1'b0;
        o_s_araddr   = '0;
        o_s_arprot   = '0;
        o_s_rready   = 1'b0;
        o_m0_arready = 1'b0;
        o_m1_arready = 1'b0;
        o_m0_rvalid  = 1'b0;
        o_m0_rdata   = '0;
        o_m0_rresp   = '0;
        o_m1_rvalid  = 1'b0;
        o_m1_rdata   = '0;
        o_m1_rresp   = '0;
        case (r_state)
            R_IDLE: if (r_grant != 2'b00) r_next = R_AR;
            R_AR: begin
                o_s_arvalid = 1'b1;
                o_s_araddr  = r_gnt ? i_m1_araddr : i_m0_araddr;
                o_s_arprot  = r_gnt ? i_m1_arprot : i_m0_arprot;
                if (r_gnt) o_m1_arready = i_s_arready;
                else       o_m0_arready = i_s_arready;
                if (i_s_arready) r_next = R_R;
            end
            R_R: begin
                o_s_rready = r_gnt ? i_m1_rready : i_m0_rready;
                if (r_gnt) begin
                    o_m1_rvalid = i_s_rvalid;
                    o_m1_rdata  = i_s_rdata;
                    o_m1_rresp  = i_s_rresp;
                end else begin
                    o_m0_rvalid = i_s_rvalid;
                    o_m0_rdata  = i_s_rdata;
                    o_m0_rresp  = i_s_rresp;
                end
                if (r_done) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Write state register, grant latch and per-channel done flags.
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            w_state <= W_IDLE;
            w_gnt   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && w_grant != 2'b00) w_gnt <= grant_id(w_grant);
            if (b_done) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end
        end
    end

    // Write next state and steering; AW and W proceed independently in W_AW.
    always_comb begin
        w_next       = w_state;
        o_s_awvalid  = 1'b0;
        o_s_awaddr   = '0;
        o_s_awprot   = '0;
        o_s_wvalid   = 1'b0;
        o_s_wdata    = '0;
        o_s_wstrb    = '0;
        o_s_bready   = 1'b0;
        o_m0_awready = 1'b0;
        o_m1_awready = 1'b0;
        o_m0_wready  = 1'b0;
        o_m1_wready  = 1'b0;
        o_m0_bvalid  = 1'b0;
        o_m0_bresp   = '0;
        o_m1_bvalid  = 1'b0;
        o_m1_bresp   = '0;
        case (w_state)
            W_IDLE: if (w_grant != 2'b00) w_next = W_AW;
            W_AW: begin
                if (!aw_done) begin
                    o_s_awvalid = 1'b1;
                    o_s_awaddr  = w_gnt ? i_m1_awaddr : i_m0_awaddr;
                    o_s_awprot  = w_gnt ? i_m1_awprot : i_m0_awprot;
                    if (w_gnt) o_m1_awready = i_s_awready;
                    else       o_m0_awready = i_s_awready;
                end
                if (!w_done) begin
                    o_s_wvalid = m_wvalid;
                    o_s_wdata  = w_gnt ? i_m1_wdata : i_m0_wdata;
                    o_s_wstrb  = w_gnt ? i_m1_wstrb : i_m0_wstrb;
                    if (w_gnt) o_m1_wready = i_s_wready;
                    else       o_m0_wready = i_s_wready;
                end
                if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_B;
            end
            W_B: begin
                o_s_bready = w_gnt ? i_m1_bready : i_m0_bready;
                if (w_gnt) begin
                    o_m1_bvalid = i_s_bvalid;
                    o_m1_bresp  = i_s_bresp;
                end else begin
                    o_m0_bvalid = i_s_bvalid;
                    o_m0_bresp  = i_s_bresp;
                end
                if (b_done) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050710_axil_arbiter.sv
// Directed bench for the 2-master AXI4-Lite arbiter.
module tb_ysyx_22050710_axil_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        i_m0_awvalid, i_m0_wvalid, i_m0_bready, i_m0_arvalid, i_m0_rready;
    logic [63:0] i_m0_awaddr, i_m0_wdata, i_m0_araddr;
    logic [2:0]  i_m0_awprot, i_m0_arprot;
    logic [7:0]  i_m0_wstrb;
    logic        i_m1_awvalid, i_m1_wvalid, i_m1_bready, i_m1_arvalid, i_m1_rready;
    logic [63:0] i_m1_awaddr, i_m1_wdata, i_m1_araddr;
    logic [2:0]  i_m1_awprot, i_m1_arprot;
    logic [7:0]  i_m1_wstrb;
    logic        i_s_awready, i_s_wready, i_s_bvalid, i_s_arready, i_s_rvalid;
    logic [1:0]  i_s_bresp, i_s_rresp;
    logic [63:0] i_s_rdata;

    logic        o_m0_awready, o_m0_wready, o_m0_bvalid, o_m0_arready, o_m0_rvalid;
    logic [1:0]  o_m0_bresp, o_m0_rresp;
    logic [63:0] o_m0_rdata;
    logic        o_m1_awready, o_m1_wready, o_m1_bvalid, o_m1_arready, o_m1_rvalid;
    logic [1:0]  o_m1_bresp, o_m1_rresp;
    logic [63:0] o_m1_rdata;
    logic        o_s_awvalid, o_s_wvalid, o_s_bready, o_s_arvalid, o_s_rready;
    logic [63:0] o_s_awaddr, o_s_wdata, o_s_araddr;
    logic [2:0]  o_s_awprot, o_s_arprot;
    logic [7:0]  o_s_wstrb;
    logic [1:0]  o_dbg_r_state, o_dbg_w_state;
    logic [14:0] vr_all;

    assign vr_all = {o_m0_awready, o_m0_wready, o_m0_bvalid, o_m0_arready, o_m0_rvalid,
                     o_m1_awready, o_m1_wready, o_m1_bvalid, o_m1_arready, o_m1_rvalid,
                     o_s_awvalid, o_s_wvalid, o_s_bready, o_s_arvalid, o_s_rready};

    ysyx_22050710_axil_arbiter dut (
        .i_aclk(clk), .i_arsetn(rst_n),
        .i_m0_awvalid(i_m0_awvalid), .i_m0_awaddr(i_m0_awaddr), .i_m0_awprot(i_m0_awprot), .o_m0_awready(o_m0_awready),
        .i_m0_wvalid(i_m0_wvalid), .i_m0_wdata(i_m0_wdata), .i_m0_wstrb(i_m0_wstrb), .o_m0_wready(o_m0_wready),
        .o_m0_bvalid(o_m0_bvalid), .o_m0_bresp(o_m0_bresp), .i_m0_bready(i_m0_bready),
        .i_m0_arvalid(i_m0_arvalid), .i_m0_araddr(i_m0_araddr), .i_m0_arprot(i_m0_arprot), .o_m0_arready(o_m0_arready),
        .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata), .o_m0_rresp(o_m0_rresp), .i_m0_rready(i_m0_rready),
        .i_m1_awvalid(i_m1_awvalid), .i_m1_awaddr(i_m1_awaddr), .i_m1_awprot(i_m1_awprot), .o_m1_awready(o_m1_awready),
        .i_m1_wvalid(i_m1_wvalid), .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb), .o_m1_wready(o_m1_wready),
        .o_m1_bvalid(o_m1_bvalid), .o_m1_bresp(o_m1_bresp), .i_m1_bready(i_m1_bready),
        .i_m1_arvalid(i_m1_arvalid), .i_m1_araddr(i_m1_araddr), .i_m1_arprot(i_m1_arprot), .o_m1_arready(o_m1_arready),
        .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata), .o_m1_rresp(o_m1_rresp), .i_m1_rready(i_m1_rready),
        .o_s_awvalid(o_s_awvalid), .o_s_awaddr(o_s_awaddr), .o_s_awprot(o_s_awprot), .i_s_awready(i_s_awready),
        .o_s_wvalid(o_s_wvalid), .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb), .i_s_wready(i_s_wready),
        .i_s_bvalid(i_s_bvalid), .i_s_bresp(i_s_bresp), .o_s_bready(o_s_bready),
        .o_s_arvalid(o_s_arvalid), .o_s_araddr(o_s_araddr), .o_s_arprot(o_s_arprot), .i_s_arready(i_s_arready),
        .i_s_rvalid(i_s_rvalid), .i_s_rdata(i_s_rdata), .i_s_rresp(i_s_rresp), .o_s_rready(o_s_rready),
        .o_dbg_r_state(o_dbg_r_state), .o_dbg_w_state(o_dbg_w_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        i_m0_awvalid = 0; i_m0_awaddr = '0; i_m0_awprot = '0; i_m0_wvalid = 0; i_m0_wdata = '0;
        i_m0_wstrb = '0; i_m0_bready = 0; i_m0_arvalid = 0; i_m0_araddr = '0; i_m0_arprot = '0; i_m0_rready = 0;
        i_m1_awvalid = 0; i_m1_awaddr = '0; i_m1_awprot = '0; i_m1_wvalid = 0; i_m1_wdata = '0;
        i_m1_wstrb = '0; i_m1_bready = 0; i_m1_arvalid = 0; i_m1_araddr = '0; i_m1_arprot = '0; i_m1_rready = 0;
        i_s_awready = 0; i_s_wready = 0; i_s_bvalid = 0; i_s_bresp = '0;
        i_s_arready = 0; i_s_rvalid = 0; i_s_rdata = '0; i_s_rresp = '0;
    endtask

    // Slave-side read driver: accepts one AR (bounded wait), returns one R beat.
    task automatic slave_read(input logic [63:0] data, output logic [63:0] addr_seen,
                              output logic [1:0] who, output logic [63:0] data_seen, output bit ok);
        int n;
        ok = 0; addr_seen = '0; who = '0; data_seen = '0; n = 0;
        i_s_arready = 1;
        #1;
        while (!o_s_arvalid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (o_s_arvalid) begin
            addr_seen = o_s_araddr;
            @(negedge clk);
            i_s_arready = 0; i_s_rvalid = 1; i_s_rdata = data; i_s_rresp = 2'b00;
            #1;
            who = {o_m1_rvalid, o_m0_rvalid};
            data_seen = o_m1_rvalid ? o_m1_rdata : o_m0_rdata;
            ok = o_s_rready;
            @(negedge clk);
            i_s_rvalid = 0; i_s_rdata = '0;
        end else begin
            i_s_arready = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        total++; if (vr_all !== 15'd0) begin bad++; $display("FAIL reset_valid_ready got=%h exp=0", vr_all); end
        total++; if ({o_s_araddr, o_s_awaddr, o_s_wdata} !== 192'd0) begin bad++; $display("FAIL reset_s_addr_data got=%h/%h/%h exp=0", o_s_araddr, o_s_awaddr, o_s_wdata); end
        total++; if ({o_dbg_r_state, o_dbg_w_state} !== 4'd0) begin bad++; $display("FAIL reset_state got=%b exp=0000", {o_dbg_r_state, o_dbg_w_state}); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        i_m0_arvalid = 1; i_m0_araddr = 64'h8000_0000; i_s_arready = 1; i_m0_rready = 1;
        #1;
        total++; if (o_s_arvalid !== 1'b0) begin bad++; $display("FAIL rd1_arb_latency got=%b exp=0", o_s_arvalid); end
        @(negedge clk); #1;
        total++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== 64'h8000_0000) begin bad++; $display("FAIL rd1_s_ar got=%b/%h exp=1/80000000", o_s_arvalid, o_s_araddr); end
        total++; if (o_m0_arready !== 1'b1 || o_m1_arready !== 1'b0) begin bad++; $display("FAIL rd1_arready got=%b%b exp=01", o_m1_arready, o_m0_arready); end
        @(negedge clk);
        i_m0_arvalid = 0; i_s_arready = 0; i_s_rvalid = 1; i_s_rdata = 64'h413; i_s_rresp = 2'b00;
        #1;
        total++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 64'h413 || o_m0_rresp !== 2'b00) begin bad++; $display("FAIL rd1_m0_r got=%b/%h/%b exp=1/413/00", o_m0_rvalid, o_m0_rdata, o_m0_rresp); end
        total++; if (o_m1_rvalid !== 1'b0 || o_s_rready !== 1'b1) begin bad++; $display("FAIL rd1_m1_rvalid/s_rready got=%b/%b exp=0/1", o_m1_rvalid, o_s_rready); end
        @(negedge clk);
        i_s_rvalid = 0; i_s_rdata = '0; i_m0_rready = 0;
        #1;
        total++; if (o_dbg_r_state !== 2'd0 || o_m0_rvalid !== 1'b0) begin bad++; $display("FAIL rd1_back_idle got=%0d/%b exp=0/0", o_dbg_r_state, o_m0_rvalid); end
    endtask

    task automatic test_read_tie();
        logic [63:0] a, d;
        logic [1:0]  w;
        bit          ok;
        test_reset();
        i_m0_arvalid = 1; i_m0_araddr = 64'h8000_0000;
        i_m1_arvalid = 1; i_m1_araddr = 64'h8000_1000;
        i_m0_rready = 1; i_m1_rready = 1;
        slave_read(64'h11, a, w, d, ok);
        total++; if (!ok || a !== 64'h8000_1000 || w !== 2'b10 || d !== 64'h11) begin bad++; $display("FAIL tie_first got=%0b/%h/%b/%h exp=1/80001000/10/11", ok, a, w, d); end
        slave_read(64'h22, a, w, d, ok);
        total++; if (!ok || a !== 64'h8000_0000 || w !== 2'b01 || d !== 64'h22) begin bad++; $display("FAIL tie_second got=%0b/%h/%b/%h exp=1/80000000/01/22", ok, a, w, d); end
        slave_read(64'h33, a, w, d, ok);
        total++; if (!ok || a !== 64'h8000_1000 || w !== 2'b10 || d !== 64'h33) begin bad++; $display("FAIL tie_third got=%0b/%h/%b/%h exp=1/80001000/10/33", ok, a, w, d); end
        i_m0_arvalid = 0; i_m1_arvalid = 0; i_m0_rready = 0; i_m1_rready = 0;
        @(negedge clk);
    endtask

    task automatic test_write_slverr();
        i_m1_awvalid = 1; i_m1_awaddr = 64'h8000_2000; i_s_awready = 1; i_s_wready = 1;
        @(negedge clk); #1;
        total++; if (o_s_awvalid !== 1'b1 || o_s_awaddr !== 64'h8000_2000 || o_m1_awready !== 1'b1) begin bad++; $display("FAIL wr_aw got=%b/%h/%b exp=1/80002000/1", o_s_awvalid, o_s_awaddr, o_m1_awready); end
        total++; if (o_s_wvalid !== 1'b0) begin bad++; $display("FAIL wr_w_held got=%b exp=0", o_s_wvalid); end
        @(negedge clk);
        i_m1_awvalid = 0; i_m1_wvalid = 1; i_m1_wdata = 64'hdead_beef; i_m1_wstrb = 8'h0f;
        #1;
        total++; if (o_s_awvalid !== 1'b0 || o_s_wvalid !== 1'b1 || o_s_wdata !== 64'hdead_beef || o_s_wstrb !== 8'h0f) begin bad++; $display("FAIL wr_w got=%b/%b/%h/%h exp=0/1/deadbeef/0f", o_s_awvalid, o_s_wvalid, o_s_wdata, o_s_wstrb); end
        total++; if (o_m1_wready !== 1'b1 || o_m0_wready !== 1'b0) begin bad++; $display("FAIL wr_wready got=%b%b exp=10", o_m1_wready, o_m0_wready); end
        @(negedge clk);
        i_m1_wvalid = 0; i_s_awready = 0; i_s_wready = 0; i_s_bvalid = 1; i_s_bresp = 2'b10; i_m1_bready = 1;
        #1;
        total++; if (o_m1_bvalid !== 1'b1 || o_m1_bresp !== 2'b10 || o_s_bready !== 1'b1) begin bad++; $display("FAIL wr_b got=%b/%b/%b exp=1/10/1", o_m1_bvalid, o_m1_bresp, o_s_bready); end
        total++; if (o_m0_bvalid !== 1'b0) begin bad++; $display("FAIL wr_m0_bvalid got=%b exp=0", o_m0_bvalid); end
        @(negedge clk);
        i_s_bvalid = 0; i_s_bresp = '0; i_m1_bready = 0;
        #1;
        total++; if (o_dbg_w_state !== 2'd0 || o_m0_bvalid !== 1'b0 || o_m1_bvalid !== 1'b0) begin bad++; $display("FAIL wr_back_idle got=%0d/%b/%b exp=0/0/0", o_dbg_w_state, o_m0_bvalid, o_m1_bvalid); end
    endtask

    task automatic test_concurrent();
        i_m0_arvalid = 1; i_m0_araddr = 64'h8000_0040;
        i_m1_awvalid = 1; i_m1_awaddr = 64'h8000_0080; i_m1_wvalid = 1; i_m1_wdata = 64'h55; i_m1_wstrb = 8'hff;
        i_s_arready = 1; i_s_awready = 1; i_s_wready = 1;
        @(negedge clk); #1;
        total++; if ({o_s_arvalid, o_s_awvalid, o_s_wvalid} !== 3'b111) begin bad++; $display("FAIL conc_addr got=%b exp=111", {o_s_arvalid, o_s_awvalid, o_s_wvalid}); end
        total++; if (o_s_araddr !== 64'h8000_0040 || o_s_awaddr !== 64'h8000_0080) begin bad++; $display("FAIL conc_addrs got=%h/%h exp=80000040/80000080", o_s_araddr, o_s_awaddr); end
        @(negedge clk);
        i_m0_arvalid = 0; i_m1_awvalid = 0; i_m1_wvalid = 0; i_s_arready = 0; i_s_awready = 0; i_s_wready = 0;
        i_s_rvalid = 1; i_s_rdata = 64'h77; i_s_bvalid = 1; i_s_bresp = 2'b00; i_m0_rready = 1; i_m1_bready = 1;
        #1;
        total++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 64'h77 || o_m1_bvalid !== 1'b1) begin bad++; $display("FAIL conc_resp got=%b/%h/%b exp=1/77/1", o_m0_rvalid, o_m0_rdata, o_m1_bvalid); end
        @(negedge clk);
        i_s_rvalid = 0; i_s_rdata = '0; i_s_bvalid = 0; i_m0_rready = 0; i_m1_bready = 0;
        #1;
        total++; if ({o_dbg_r_state, o_dbg_w_state} !== 4'd0) begin bad++; $display("FAIL conc_idle got=%b exp=0000", {o_dbg_r_state, o_dbg_w_state}); end
    endtask

    task automatic test_ar_stall();
        i_m0_arvalid = 1; i_m0_araddr = 64'h8000_3000; i_m0_arprot = 3'b101; i_s_arready = 0;
        @(negedge clk);
        i_m1_arvalid = 1; i_m1_araddr = 64'h8000_4000;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== 64'h8000_3000 || o_s_arprot !== 3'b101) begin bad++; $display("FAIL stall_s_ar[%0d] got=%b/%h/%b exp=1/80003000/101", i, o_s_arvalid, o_s_araddr, o_s_arprot); end
            total++; if (o_m0_arready !== 1'b0 || o_m1_arready !== 1'b0) begin bad++; $display("FAIL stall_arready[%0d] got=%b%b exp=00", i, o_m1_arready, o_m0_arready); end
            @(negedge clk);
        end
        i_s_arready = 1;
        #1;
        total++; if (o_m0_arready !== 1'b1 || o_m1_arready !== 1'b0 || o_s_araddr !== 64'h8000_3000) begin bad++; $display("FAIL stall_release got=%b%b/%h exp=01/80003000", o_m1_arready, o_m0_arready, o_s_araddr); end
        @(negedge clk);
        i_m0_arvalid = 0; i_m1_arvalid = 0; i_s_arready = 0; i_s_rvalid = 1; i_s_rdata = 64'h99; i_m0_rready = 1;
        #1;
        total++; if (o_m0_rvalid !== 1'b1 || o_m1_rvalid !== 1'b0) begin bad++; $display("FAIL stall_r got=%b%b exp=01", o_m1_rvalid, o_m0_rvalid); end
        @(negedge clk);
        i_s_rvalid = 0; i_s_rdata = '0; i_m0_rready = 0; i_m0_arprot = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [63:0] a, d;
        logic [1:0]  w;
        bit          ok;
        test_reset();
        i_m1_arvalid = 1; i_m1_araddr = 64'h8000_5000; i_s_arready = 1;
        repeat (2) @(negedge clk);
        i_m1_arvalid = 0; i_s_arready = 0; i_s_rvalid = 1; i_s_rdata = 64'h1111; i_m1_rready = 0;
        #1;
        total++; if (o_m1_rvalid !== 1'b1 || o_dbg_r_state !== 2'd2) begin bad++; $display("FAIL rst_mid_pre got=%b/%0d exp=1/2", o_m1_rvalid, o_dbg_r_state); end
        #2 rst_n = 0;
        #1;
        total++; if (vr_all !== 15'd0 || o_dbg_r_state !== 2'd0) begin bad++; $display("FAIL rst_mid_async got=%h/%0d exp=0/0", vr_all, o_dbg_r_state); end
        @(negedge clk);
        i_s_rvalid = 0; i_s_rdata = '0;
        rst_n = 1;
        @(negedge clk);
        i_m1_arvalid = 1; i_m1_araddr = 64'h8000_6000; i_m1_rready = 1;
        slave_read(64'h2222, a, w, d, ok);
        i_m1_arvalid = 0; i_m1_rready = 0;
        total++; if (!ok || a !== 64'h8000_6000 || w !== 2'b10 || d !== 64'h2222) begin bad++; $display("FAIL rst_mid_fresh got=%0b/%h/%b/%h exp=1/80006000/10/2222", ok, a, w, d); end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_read_tie();
        test_write_slverr();
        test_concurrent();
        test_ar_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
